l2_cacheline_adapter: RTL and testbench
=======================================

// Module: l2_cacheline_adapter
// PURPOSE
//  Sits directly downstream of the L2 cache datapath/control, between the L2 and physical memory.
//  Converts one 256-bit line read (fill) or write (dirty eviction) into a burst of 64-bit memory beats.
//  On a fill it assembles the beats into a full line for pmem_rdata.
//  On an eviction it serialises pmem_wdata to memory.
//  Returns a single-cycle response to the L2 when the whole line has transferred.
// PARAMETERS
//  S_LINE   256  line width in bits (L2 pmem_rdata/pmem_wdata width)
//  S_BURST  64   memory beat width in bits
//  BEATS    4    S_LINE/S_BURST, derived; not overridden independently
// PORTS
//  clk           in   1    clock; all state updates on rising edge
//  reset         in   1    synchronous, active-low reset (0 = reset)
//  line_addr_i   in   32   L2 pmem_address; low 5 bits ignored
//  line_read_i   in   1    L2 requests line fill
//  line_write_i  in   1    L2 requests line write-back
//  line_wdata_i  in   256  L2 pmem_wdata (eviction line)
//  line_rdata_o  out  256  assembled fill line to L2 pmem_rdata
//  line_resp_o   out  1    one-cycle pulse: line transfer complete
//  mem_addr_o    out  32   burst base address, {line_addr[31:5],5'b0}
//  mem_read_o    out  1    memory read burst request
//  mem_write_o   out  1    memory write burst request
//  mem_wdata_o   out  64   current write beat
//  mem_rdata_i   in   64   current read beat
//  mem_resp_i    in   1    memory beat accepted (write) / beat valid (read), one per beat
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - state=IDLE, beat counter=0.
//   - line_resp_o, mem_read_o and mem_write_o are all 0.
//   - line_rdata_o=0 and mem_addr_o=0.
//   - Applies even mid-burst. The partial line is discarded and no line_resp_o is issued.
//  States: IDLE, READ, WRITE, DONE.
//  IDLE:
//   - line_write_i=1 -> WRITE. line_write_i has priority when both requests are high.
//   - else line_read_i=1 -> READ.
//   - On accept, latch: addr -> mem_addr_o (low 5 bits zeroed), line_wdata_i (writes only), counter=0.
//   - mem_resp_i in IDLE or DONE is ignored.
//  READ:
//   - mem_read_o=1 for the whole state.
//   - Each cycle with mem_resp_i=1: line_rdata_o[64*cnt +: 64] <= mem_rdata_i, cnt++.
//   - Beat 0 is the lowest 64 bits. Gaps between beats are legal; state and counter hold.
//   - On the edge capturing beat BEATS-1 -> DONE.
//  WRITE:
//   - mem_write_o=1 for the whole state.
//   - mem_wdata_o = latched_line[64*cnt +: 64] (combinational from counter).
//   - Counter advances on mem_resp_i=1. After beat BEATS-1 is accepted -> DONE.
//   - mem_wdata_o is 0 outside WRITE.
//  DONE:
//   - line_resp_o=1 for exactly this one cycle; mem_read_o=mem_write_o=0.
//   - Next state is IDLE unconditionally.
//  Latency: request accepted at edge N.
//   - Back-to-back beats: mem requests high in N..N+3, line_resp_o in cycle N+4.
//   - Each stalled cycle adds one.
//  Requester rule: L2 holds its request high until it sees line_resp_o, and drops it the following cycle.
//   - Because DONE->IDLE consumes that cycle, no duplicate transfer is started.
//   - A request still high in IDLE after DONE is treated as a new transfer (legal back-to-back).
//  line_rdata_o holds its value from DONE until the next READ overwrites beat 0.
//   - L2 samples it in the line_resp_o cycle.
//  Upstream inputs (line_addr_i, line_wdata_i) may change after acceptance without effect.
//  Counter is log2(BEATS) bits and wraps to 0 on entering DONE.
//  Request inputs are ignored outside IDLE.
// TESTING
//  1. Reset: hold reset=0 2 cycles with line_read_i=1 -> mem_read_o=0, line_resp_o=0, line_rdata_o=0.
//  2. Fill: addr 0x0000_1234, read_i=1, beats 0x11..11/0x22..22/0x33..33/0x44..44 back-to-back ->
//     - mem_addr_o=0x0000_1220; resp at accept+4.
//     - line_rdata_o={0x44..,0x33..,0x22..,0x11..}.
//  3. Evict: line 0x0..0_DDDD..._CCCC..._BBBB..._AAAA, write_i=1, resp_i with 1-cycle gaps ->
//     - mem_wdata_o steps AAAA..->BBBB..->CCCC..->DDDD.. only on resp.
//     - line_resp_o at accept+8.
//  4. Simultaneous read_i=write_i=1 -> WRITE burst first (mem_write_o=1, mem_read_o=0).
//  5. Change line_wdata_i/addr after accept -> mem_wdata_o/mem_addr_o keep latched values.
//  6. Assert reset after 2 read beats -> next cycle mem_read_o=0, no line_resp_o.
//     - A new read collects all 4 beats correctly.

Source files
------------

// File: rtl/l2_cacheline_adapter.sv
// L2 <-> physical memory line adapter.
// Splits one cache line into a burst of memory beats (fill or eviction).
module l2_cacheline_adapter #(
    parameter int S_LINE  = 256,
    parameter int S_BURST = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          line_addr_i,
    input  logic                 line_read_i,
    input  logic                 line_write_i,
    input  logic [S_LINE-1:0]    line_wdata_i,
    output logic [S_LINE-1:0]    line_rdata_o,
    output logic                 line_resp_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [S_BURST-1:0]   mem_wdata_o,
    input  logic [S_BURST-1:0]   mem_rdata_i,
    input  logic                 mem_resp_i
);

    localparam int BEATS = S_LINE / S_BURST;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(S_LINE / 8);
    localparam logic [31:0] AMASK = ~((32'd1 << OFS) - 32'd1);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         addr_q;
    logic [S_LINE-1:0]   line_q;
    logic [S_LINE-1:0]   rdata_q;
    logic                resp_q;
    logic                rd_q;
    logic                wr_q;
    logic [S_BURST-1:0]  wbeat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    // Write-back wins so a dirty victim leaves before its refill.
                    if (line_write_i) begin
                        state_q <= WRITE;
                        addr_q  <= line_addr_i & AMASK;
                        line_q  <= line_wdata_i;
                        cnt_q   <= '0;
                        wr_q    <= 1'b1;
                    end else if (line_read_i) begin
                        state_q <= READ;
                        addr_q  <= line_addr_i & AMASK;
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CW'(b)) begin
                                rdata_q[b*S_BURST +: S_BURST] <= mem_rdata_i;
                            end
                        end
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp_i) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wbeat = '0;
        if (wr_q) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CW'(b)) begin
                    wbeat = line_q[b*S_BURST +: S_BURST];
                end
            end
        end
    end

    assign line_rdata_o = rdata_q;
    assign line_resp_o  = resp_q;
    assign mem_addr_o   = addr_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign mem_wdata_o  = wbeat;

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Bench for l2_cacheline_adapter: vector table, corner sequences
// and random transfers against a line-level reference model.
module tb_l2_cacheline_adapter;

    logic          clk;
    logic          reset;
    logic [31:0]   line_addr_i;
    logic          line_read_i;
    logic          line_write_i;
    logic [255:0]  line_wdata_i;
    logic [255:0]  line_rdata_o;
    logic          line_resp_o;
    logic [31:0]   mem_addr_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic [63:0]   mem_wdata_o;
    logic [63:0]   mem_rdata_i;
    logic          mem_resp_i;

    int total = 0;
    int bad   = 0;

    l2_cacheline_adapter dut (
        .clk          (clk),
        .reset        (reset),
        .line_addr_i  (line_addr_i),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_wdata_i (line_wdata_i),
        .line_rdata_o (line_rdata_o),
        .line_resp_o  (line_resp_o),
        .mem_addr_o   (mem_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_resp_i   (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [255:0]  line;
        logic [15:0]   gaps;
        bit            noise;
        logic [31:0]   exp_addr;
        logic          exp_wr;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic [255:0] l, input int i);
        logic [255:0] s;
        s = l >> (64 * i);
        return s[63:0];
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer as the L2 and memory would perform it.
    task automatic xfer(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] line,
                        input logic [15:0] gaps, input bit noise,
                        input logic [31:0] exp_addr, input logic exp_wr);
        int g;
        line_addr_i  = addr;
        line_wdata_i = line;
        line_read_i  = rd;
        line_write_i = wr;
        mem_resp_i   = 1'b0;
        tick();
        chk("acc_addr", mem_addr_o, exp_addr);
        chk("acc_wr", mem_write_o, exp_wr);
        chk("acc_rd", mem_read_o, !exp_wr);
        line_addr_i  = $urandom;
        line_wdata_i = rnd_line();
        for (int i = 0; i < 4; i++) begin
            g = int'(gaps[4*i +: 4]);
            for (int j = 0; j < g; j++) begin
                mem_resp_i  = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
                tick();
                chk("gap_resp", line_resp_o, 1'b0);
                chk("gap_req", mem_read_o | mem_write_o, 1'b1);
                if (exp_wr) chk("gap_wdata", mem_wdata_o, beat(line, i));
            end
            if (exp_wr) chk("wdata", mem_wdata_o, beat(line, i));
            chk("addr_hold", mem_addr_o, exp_addr);
            mem_resp_i  = 1'b1;
            mem_rdata_i = beat(line, i);
            tick();
            if (i < 3) chk("early_resp", line_resp_o, 1'b0);
        end
        mem_resp_i  = noise;
        mem_rdata_i = {$urandom, $urandom};
        chk("resp", line_resp_o, 1'b1);
        chk("done_req", {mem_read_o, mem_write_o}, 2'b00);
        chk("done_wdata", mem_wdata_o, 64'h0);
        if (!exp_wr) chk("fill", line_rdata_o, line);
        tick();
        chk("resp_pulse", line_resp_o, 1'b0);
        chk("idle_req", {mem_read_o, mem_write_o}, 2'b00);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        mem_resp_i   = noise ? 1'($urandom) : 1'b0;
        tick();
        chk("no_dup", {mem_read_o, mem_write_o, line_resp_o}, 3'b000);
        if (!exp_wr) chk("fill_hold", line_rdata_o, line);
        mem_resp_i = 1'b0;
    endtask

    initial begin
        logic          rd;
        logic          wr;
        logic [31:0]   a;
        logic [255:0]  l;
        logic [15:0]   gp;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234,
                   {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                   16'h0000, 1'b0, 32'h0000_1220, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_4000,
                   {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                   16'h1111, 1'b1, 32'h0000_4000, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF,
                   {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5A5A_A5A5_0F0F_F0F0, 64'hDEAD_BEEF_CAFE_F00D},
                   16'h0203, 1'b0, 32'hFFFF_FFE0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h8000_001F,
                   {64'h1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
                   16'h3000, 1'b1, 32'h8000_0000, 1'b0};

        reset        = 1'b0;
        line_addr_i  = 32'h0000_1234;
        line_read_i  = 1'b1;
        line_write_i = 1'b0;
        line_wdata_i = '0;
        mem_rdata_i  = '0;
        mem_resp_i   = 1'b0;

        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_rd", mem_read_o, 1'b0);
            chk("rst_resp", line_resp_o, 1'b0);
            chk("rst_rdata", line_rdata_o, 256'h0);
            chk("rst_addr", mem_addr_o, 32'h0);
        end
        line_read_i = 1'b0;
        reset       = 1'b1;
        tick();
        chk("idle_after_rst", {mem_read_o, mem_write_o}, 2'b00);

        foreach (tbl[i]) begin
            xfer(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].line,
                 tbl[i].gaps, tbl[i].noise, tbl[i].exp_addr, tbl[i].exp_wr);
        end

        // Reset in the middle of a fill: partial line dropped, no response.
        line_addr_i = 32'h0000_2040;
        line_read_i = 1'b1;
        tick();
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'h1111_2222_3333_4444;
        tick();
        mem_rdata_i = 64'h5555_6666_7777_8888;
        tick();
        reset      = 1'b0;
        mem_resp_i = 1'b0;
        tick();
        chk("mid_rst_rd", mem_read_o, 1'b0);
        chk("mid_rst_resp", line_resp_o, 1'b0);
        chk("mid_rst_rdata", line_rdata_o, 256'h0);
        reset       = 1'b1;
        line_read_i = 1'b0;
        tick();
        chk("mid_rst_idle", {mem_read_o, line_resp_o}, 2'b00);
        xfer(1'b1, 1'b0, 32'h0000_2040, rnd_line(), 16'h0000, 1'b0,
             32'h0000_2040, 1'b0);

        // Random transfers against the line-level model.
        for (int n = 0; n < 30; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            a = $urandom;
            l = rnd_line();
            for (int k = 0; k < 4; k++) gp[4*k +: 4] = 4'($urandom_range(0, 2));
            xfer(rd, wr, a, l, gp, 1'($urandom), {a[31:5], 5'b0}, wr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
